// File: rtl/matrix_load_if.sv
// Operand-loader bus: serial element stream in, two packed matrices out.
//
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready.
// The producer holds in_valid and its payload (in_data, in_image, in_last)
// stable until the beat transfers. in_ready depends only on loader state,
// never combinationally on in_valid or mat_ack. The consumer samples
// matA/matB/imageA/imageB only while mat_valid=1 and pulses mat_ack once it
// has taken the result.
interface matrix_load_if #(
    parameter int A_N   = 8,
    parameter int A_M   = 8,
    parameter int B_N   = 8,
    parameter int B_M   = 8,
    parameter int WIDTH = 16
);
    logic                                   in_valid;
    logic                                   in_ready;
    logic [WIDTH-1:0]                       in_data;
    logic                                   in_image;
    logic                                   in_last;
    logic [A_M-1:0][A_N-1:0][WIDTH-1:0]     matA;
    logic [B_M-1:0][B_N-1:0][WIDTH-1:0]     matB;
    logic                                   imageA;
    logic                                   imageB;
    logic                                   mat_valid;
    logic                                   mat_ack;
    logic                                   err;
    // Loader FSM state (0=LOAD_A, 1=LOAD_B, 2=FULL), exposed for checkers.
    logic [1:0]                             load_state;

    // Loader side.
    modport slave (
        input  in_valid, in_data, in_image, in_last, mat_ack,
        output in_ready, matA, matB, imageA, imageB, mat_valid, err, load_state
    );

    // Stream producer / matrix consumer side.
    modport master (
        output in_valid, in_data, in_image, in_last, mat_ack,
        input  in_ready, matA, matB, imageA, imageB, mat_valid, err, load_state
    );
endinterface

// File: rtl/matrix_load.sv
// Operand loader for the combinational matrix multiplier.
// Assembles a row-major element stream into matrix A, then matrix B, and
// holds both (plus their image flags) statically with mat_valid until the
// consumer acknowledges. Element count frames each matrix; in_last is only
// cross-checked and a disagreement sets a sticky err flag.
module matrix_load #(
    parameter int A_N   = 8,
    parameter int A_M   = 8,
    parameter int B_N   = 8,
    parameter int B_M   = 8,
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    matrix_load_if.slave  bus
);
    // Counter widths; a dimension of 1 still gets a 1-bit counter.
    localparam int AR_W = (A_M > 1) ? $clog2(A_M) : 1;
    localparam int AC_W = (A_N > 1) ? $clog2(A_N) : 1;
    localparam int BR_W = (B_M > 1) ? $clog2(B_M) : 1;
    localparam int BC_W = (B_N > 1) ? $clog2(B_N) : 1;

    localparam logic [AR_W-1:0] A_ROW_LAST = AR_W'(A_M - 1);
    localparam logic [AC_W-1:0] A_COL_LAST = AC_W'(A_N - 1);
    localparam logic [BR_W-1:0] B_ROW_LAST = BR_W'(B_M - 1);
    localparam logic [BC_W-1:0] B_COL_LAST = BC_W'(B_N - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t          state;
    logic [AR_W-1:0] row_a;
    logic [AC_W-1:0] col_a;
    logic [BR_W-1:0] row_b;
    logic [BC_W-1:0] col_b;

    logic ready;
    logic beat;
    logic a_first;
    logic a_final;
    logic b_first;
    logic b_final;

    // Ready is a pure decode of the registered state.
    assign ready = (state != FULL);
    assign beat  = bus.in_valid && ready;

    // Position decodes for the element about to be written.
    assign a_first = (row_a == '0) && (col_a == '0);
    assign a_final = (row_a == A_ROW_LAST) && (col_a == A_COL_LAST);
    assign b_first = (row_b == '0) && (col_b == '0);
    assign b_final = (row_b == B_ROW_LAST) && (col_b == B_COL_LAST);

    assign bus.in_ready   = ready;
    assign bus.load_state = state;

    // Loader FSM: counters, holding registers, image flags, mat_valid, err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= LOAD_A;
            row_a         <= '0;
            col_a         <= '0;
            row_b         <= '0;
            col_b         <= '0;
            bus.matA      <= '0;
            bus.matB      <= '0;
            bus.imageA    <= 1'b0;
            bus.imageB    <= 1'b0;
            bus.mat_valid <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (beat) begin
                        bus.matA[row_a][col_a] <= bus.in_data;
                        if (a_first) begin
                            bus.imageA <= bus.in_image;
                        end
                        // Count is authoritative; in_last is only checked.
                        if (bus.in_last != a_final) begin
                            bus.err <= 1'b1;
                        end
                        if (a_final) begin
                            row_a <= '0;
                            col_a <= '0;
                            state <= LOAD_B;
                        end else if (col_a == A_COL_LAST) begin
                            col_a <= '0;
                            row_a <= row_a + 1'b1;
                        end else begin
                            col_a <= col_a + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (beat) begin
                        bus.matB[row_b][col_b] <= bus.in_data;
                        if (b_first) begin
                            bus.imageB <= bus.in_image;
                        end
                        if (bus.in_last != b_final) begin
                            bus.err <= 1'b1;
                        end
                        if (b_final) begin
                            row_b         <= '0;
                            col_b         <= '0;
                            state         <= FULL;
                            bus.mat_valid <= 1'b1;
                        end else if (col_b == B_COL_LAST) begin
                            col_b <= '0;
                            row_b <= row_b + 1'b1;
                        end else begin
                            col_b <= col_b + 1'b1;
                        end
                    end
                end
                FULL: begin
                    // Operands stay frozen; no beat is possible here.
                    if (bus.mat_ack) begin
                        state         <= LOAD_A;
                        bus.mat_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= LOAD_A;
                    bus.mat_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
